// File: rtl/sqrt_req_sequencer.sv
// sqrt_req_sequencer: buffers operands in a small FIFO and drives the sqrt
// engine's start/busy/valid handshake one operation at a time, returning each
// result tagged with its operand on a valid/ready stream.
// Optional build macro: SQRT_SEQ_CHECK_EN adds check_err_o, a sticky flag set
// when a captured result is not floor(sqrt(operand)).
module sqrt_req_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_valid_i,
  input  logic [31:0]            op_data_i,
  output logic                   op_ready_o,
  output logic [31:0]            eng_a_o,
  output logic                   eng_start_o,
  input  logic [31:0]            eng_result_i,
  input  logic                   eng_valid_i,
  input  logic                   eng_busy_i,
  output logic                   res_valid_o,
  output logic [31:0]            res_data_o,
  output logic [31:0]            res_operand_o,
  input  logic                   res_ready_i,
  output logic                   timeout_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef SQRT_SEQ_CHECK_EN
  ,
  output logic                   check_err_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic          push, pop;

  assign op_ready_o = (count_o != FULL_CNT);
  assign push       = op_valid_i && op_ready_o;
  assign pop        = (state == ISSUE);

  // Operand storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= op_data_i;
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

`ifdef SQRT_SEQ_CHECK_EN
  logic [63:0] chk_r, chk_a, chk_r1;
  logic        chk_bad;

  // Result sanity: r*r <= a < (r+1)*(r+1), evaluated at 64 bits.
  always_comb begin
    chk_r   = {32'd0, eng_result_i};
    chk_a   = {32'd0, eng_a_o};
    chk_r1  = chk_r + 64'd1;
    chk_bad = (chk_r * chk_r > chk_a) || (chk_r1 * chk_r1 <= chk_a);
  end
`endif

  // Sequencer FSM; all engine-facing and result outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      eng_a_o       <= '0;
      eng_start_o   <= 1'b0;
      res_valid_o   <= 1'b0;
      res_data_o    <= '0;
      res_operand_o <= '0;
      timeout_o     <= 1'b0;
      timer         <= '0;
`ifdef SQRT_SEQ_CHECK_EN
      check_err_o   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Busy guard keeps a late-finishing engine (e.g. after a timeout)
          // from seeing a start while it is still working.
          if (count_o != '0 && !eng_busy_i) begin
            eng_a_o     <= mem[rd_ptr];
            eng_start_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start_o <= 1'b0;
          timer       <= '0;
          state       <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // eng_valid_i may still be high from the previous result, so only
          // a rising busy proves this operation was accepted.
          if (eng_busy_i) begin
            timer <= timer + 1'b1;
            state <= WAIT_DONE;
          end else if (timer == TMO_LAST) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (eng_valid_i && !eng_busy_i) begin
            res_data_o    <= eng_result_i;
            res_operand_o <= eng_a_o;
            res_valid_o   <= 1'b1;
`ifdef SQRT_SEQ_CHECK_EN
            check_err_o   <= check_err_o | chk_bad;
`endif
            state         <= OUTPUT;
          end else if (timer == TMO_LAST) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        OUTPUT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_req_sequencer.sv
// Directed bench for sqrt_req_sequencer with a behavioural sqrt engine that
// can delay its busy response, never respond, or return a wrong result.
module tb_sqrt_req_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid_i = 1'b0;
  logic [31:0] op_data_i = '0;
  logic        op_ready_o;
  logic [31:0] eng_a_o;
  logic        eng_start_o;
  logic [31:0] eng_result_i;
  logic        eng_valid_i;
  logic        eng_busy_i;
  logic        res_valid_o;
  logic [31:0] res_data_o;
  logic [31:0] res_operand_o;
  logic        res_ready_i = 1'b0;
  logic        timeout_o;
  logic [2:0]  count_o;
`ifdef SQRT_SEQ_CHECK_EN
  logic        check_err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // engine model controls
  bit  eng_nobusy = 1'b0;
  bit  eng_bad    = 1'b0;
  int  eng_dly    = 0;
  int  start_count;
  bit  start_while_busy;
  bit  eng_pending;
  int  eng_wait, eng_cnt;
  logic [31:0] eng_lat_a;

  sqrt_req_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid_i    (op_valid_i),
    .op_data_i     (op_data_i),
    .op_ready_o    (op_ready_o),
    .eng_a_o       (eng_a_o),
    .eng_start_o   (eng_start_o),
    .eng_result_i  (eng_result_i),
    .eng_valid_i   (eng_valid_i),
    .eng_busy_i    (eng_busy_i),
    .res_valid_o   (res_valid_o),
    .res_data_o    (res_data_o),
    .res_operand_o (res_operand_o),
    .res_ready_i   (res_ready_i),
    .timeout_o     (timeout_o),
    .count_o       (count_o)
`ifdef SQRT_SEQ_CHECK_EN
    ,
    .check_err_o   (check_err_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] isqrt(input logic [31:0] a);
    logic [63:0] r;
    r = 64'd0;
    while ((r + 64'd1) * (r + 64'd1) <= {32'd0, a}) r = r + 64'd1;
    return r[31:0];
  endfunction

  // Behavioural engine: optional start-to-busy delay, 4 busy cycles, valid
  // held high from completion until the next accepted start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_busy_i       <= 1'b0;
      eng_valid_i      <= 1'b0;
      eng_result_i     <= '0;
      eng_pending      <= 1'b0;
      eng_wait         <= 0;
      eng_cnt          <= 0;
      eng_lat_a        <= '0;
      start_count      <= 0;
      start_while_busy <= 1'b0;
    end else begin
      if (eng_start_o) begin
        start_count <= start_count + 1;
        if (eng_busy_i) start_while_busy <= 1'b1;
      end
      if (eng_start_o && !eng_nobusy) begin
        eng_lat_a <= eng_a_o;
        if (eng_dly == 0) begin
          eng_busy_i  <= 1'b1;
          eng_valid_i <= 1'b0;
          eng_cnt     <= 3;
        end else begin
          eng_pending <= 1'b1;
          eng_wait    <= eng_dly;
        end
      end else if (eng_pending) begin
        if (eng_wait <= 1) begin
          eng_pending <= 1'b0;
          eng_busy_i  <= 1'b1;
          eng_valid_i <= 1'b0;
          eng_cnt     <= 3;
        end else begin
          eng_wait <= eng_wait - 1;
        end
      end else if (eng_busy_i) begin
        if (eng_cnt == 0) begin
          eng_busy_i   <= 1'b0;
          eng_valid_i  <= 1'b1;
          eng_result_i <= eng_bad ? isqrt(eng_lat_a) - 32'd1 : isqrt(eng_lat_a);
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  // Present one operand starting at the current negedge; returns at the
  // negedge after it was accepted, or flags a stall.
  task automatic push_op(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    op_valid_i = 1'b1;
    op_data_i  = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (op_ready_o) ok = 1'b1;
      @(negedge clk);
    end
    op_valid_i = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_accept: operand %0d never accepted", d);
    end
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (res_valid_o) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic ack_res();
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_checks++; if (op_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", op_ready_o); end
    n_checks++; if (eng_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", eng_start_o); end
    n_checks++; if (eng_a_o !== 32'd0) begin n_fail++; $display("FAIL reset_eng_a: got %0d want 0", eng_a_o); end
    n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid_o); end
    n_checks++; if (res_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_res_data: got %0d want 0", res_data_o); end
    n_checks++; if (res_operand_o !== 32'd0) begin n_fail++; $display("FAIL reset_res_operand: got %0d want 0", res_operand_o); end
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int s0;
    s0 = start_count;
    push_op(32'd64);
    n_checks++; if (eng_start_o !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b want 0", eng_start_o); end
    @(negedge clk);
    n_checks++; if (eng_start_o !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", eng_start_o); end
    n_checks++; if (eng_a_o !== 32'd64) begin n_fail++; $display("FAIL single_eng_a: got %0d want 64", eng_a_o); end
    @(negedge clk);
    n_checks++; if (eng_start_o !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b want 0", eng_start_o); end
    for (int i = 0; i < 50 && !(eng_valid_i && !eng_busy_i); i++) @(negedge clk);
    n_checks++; if (!(eng_valid_i && !eng_busy_i)) begin n_fail++; $display("FAIL single_engine_done: got busy=%b valid=%b want done", eng_busy_i, eng_valid_i); end
    n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_res_latency_early: got %b want 0", res_valid_o); end
    @(negedge clk);
    n_checks++; if (res_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_res_valid: got %b want 1", res_valid_o); end
    n_checks++; if (res_data_o !== 32'd8) begin n_fail++; $display("FAIL single_res_data: got %0d want 8", res_data_o); end
    n_checks++; if (res_operand_o !== 32'd64) begin n_fail++; $display("FAIL single_res_operand: got %0d want 64", res_operand_o); end
    ack_res();
    n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_res_clear: got %b want 0", res_valid_o); end
    n_checks++; if (start_count - s0 !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d want 1", start_count - s0); end
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", timeout_o); end
  endtask

  task automatic test_stale_valid();
    bit ok;
    push_op(32'd25);
    wait_res(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stale_first_res: got no result want 5"); end
    n_checks++; if (res_data_o !== 32'd5) begin n_fail++; $display("FAIL stale_first_data: got %0d want 5", res_data_o); end
    ack_res();
    eng_dly = 3;
    push_op(32'd9);
    wait_res(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stale_second_res: got no result want 3"); end
    n_checks++; if (res_data_o !== 32'd3) begin n_fail++; $display("FAIL stale_second_data: got %0d want 3", res_data_o); end
    n_checks++; if (res_operand_o !== 32'd9) begin n_fail++; $display("FAIL stale_second_operand: got %0d want 9", res_operand_o); end
    ack_res();
    eng_dly = 0;
  endtask

  task automatic test_fifo_full();
    logic [31:0] ops [6];
    ops[0] = 32'd0; ops[1] = 32'd1; ops[2] = 32'd4;
    ops[3] = 32'd9; ops[4] = 32'd16; ops[5] = 32'd25;
    for (int i = 0; i < 5; i++) push_op(ops[i]);
    n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count_o); end
    n_checks++; if (op_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", op_ready_o); end
    fork
      push_op(ops[5]);
      begin
        bit ok;
        for (int k = 0; k < 6; k++) begin
          wait_res(ok);
          n_checks++; if (!ok) begin n_fail++; $display("FAIL full_res_%0d: got no result want %0d", k, k); end
          n_checks++; if (res_data_o !== 32'(k)) begin n_fail++; $display("FAIL full_data_%0d: got %0d want %0d", k, res_data_o, k); end
          n_checks++; if (res_operand_o !== ops[k]) begin n_fail++; $display("FAIL full_operand_%0d: got %0d want %0d", k, res_operand_o, ops[k]); end
          ack_res();
        end
      end
    join
  endtask

  task automatic test_backpressure();
    bit ok;
    int s0;
    push_op(32'd49);
    push_op(32'd36);
    wait_res(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_res: got no result want 7"); end
    s0 = start_count;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (res_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: cycle %0d got %b want 1", i, res_valid_o); end
      n_checks++; if (res_data_o !== 32'd7) begin n_fail++; $display("FAIL bp_data_hold: cycle %0d got %0d want 7", i, res_data_o); end
      n_checks++; if (eng_start_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_start: cycle %0d got %b want 0", i, eng_start_o); end
      @(negedge clk);
    end
    n_checks++; if (start_count !== s0) begin n_fail++; $display("FAIL bp_start_count: got %0d want %0d", start_count, s0); end
    ack_res();
    wait_res(ok);
    n_checks++; if (res_data_o !== 32'd6 || !ok) begin n_fail++; $display("FAIL bp_second_data: got %0d want 6", res_data_o); end
    n_checks++; if (res_operand_o !== 32'd36) begin n_fail++; $display("FAIL bp_second_operand: got %0d want 36", res_operand_o); end
    ack_res();
  endtask

  task automatic test_timeout();
    bit ok;
    eng_nobusy = 1'b1;
    push_op(32'd100);
    for (int i = 0; i < 20 && !eng_start_o; i++) @(negedge clk);
    n_checks++; if (eng_start_o !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b want 1", eng_start_o); end
    repeat (64) @(negedge clk);
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", timeout_o); end
    @(negedge clk);
    n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", timeout_o); end
    n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL tmo_no_result: got %b want 0", res_valid_o); end
    eng_nobusy = 1'b0;
    push_op(32'd16);
    wait_res(ok);
    n_checks++; if (res_data_o !== 32'd4 || !ok) begin n_fail++; $display("FAIL tmo_next_data: got %0d want 4", res_data_o); end
    n_checks++; if (res_operand_o !== 32'd16) begin n_fail++; $display("FAIL tmo_next_operand: got %0d want 16", res_operand_o); end
    ack_res();
    n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", timeout_o); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] ops [3];
    ops[0] = 32'd1; ops[1] = 32'd4; ops[2] = 32'd9;
    res_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) push_op(ops[i]);
    for (int k = 0; k < 3; k++) begin
      wait_res(ok);
      n_checks++; if (res_data_o !== 32'(k + 1) || !ok) begin n_fail++; $display("FAIL b2b_data_%0d: got %0d want %0d", k, res_data_o, k + 1); end
      @(negedge clk);
      n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_output_len_%0d: got %b want 0", k, res_valid_o); end
      if (k < 2) begin
        @(negedge clk);
        n_checks++; if (eng_start_o !== 1'b1) begin n_fail++; $display("FAIL b2b_next_issue_%0d: got %b want 1", k, eng_start_o); end
      end
    end
    res_ready_i = 1'b0;
  endtask

`ifdef SQRT_SEQ_CHECK_EN
  task automatic test_check();
    bit ok;
    push_op(32'd64);
    wait_res(ok);
    n_checks++; if (res_data_o !== 32'd8 || !ok) begin n_fail++; $display("FAIL chk_good_data: got %0d want 8", res_data_o); end
    n_checks++; if (check_err_o !== 1'b0) begin n_fail++; $display("FAIL chk_good_flag: got %b want 0", check_err_o); end
    ack_res();
    eng_bad = 1'b1;
    push_op(32'd64);
    wait_res(ok);
    n_checks++; if (res_data_o !== 32'd7 || !ok) begin n_fail++; $display("FAIL chk_bad_forward: got %0d want 7", res_data_o); end
    n_checks++; if (check_err_o !== 1'b1) begin n_fail++; $display("FAIL chk_bad_flag: got %b want 1", check_err_o); end
    ack_res();
    eng_bad = 1'b0;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_stale_valid();
    test_fifo_full();
    test_backpressure();
    test_back_to_back();
`ifdef SQRT_SEQ_CHECK_EN
    test_check();
`endif
    test_timeout();
    n_checks++; if (start_while_busy !== 1'b0) begin n_fail++; $display("FAIL start_while_busy: got %b want 0", start_while_busy); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_req_sequencer.md
Name: sqrt_req_sequencer

Overview:
Initiator side of the sqrt engine's start/busy/valid handshake. It buffers 32-bit operands from an upstream valid/ready stream in a small FIFO, and issues one operand at a time to the sqrt engine. It waits for completion and returns each result on a downstream valid/ready stream, tagged with its operand. It sits between a producer (CPU or DMA) and the sqrt engine. It is the only agent that drives the engine's a_i and start_i.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, minimum 2)
TIMEOUT_CYCLES, 64, maximum cycles to wait for engine busy or done before aborting an operation

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
op_valid_i  in  1  upstream operand valid
op_data_i  in  32  upstream operand
op_ready_o  out  1  FIFO not full
eng_a_o  out  32  operand to engine a_i
eng_start_o  out  1  one-cycle start pulse to engine start_i
eng_result_i  in  32  engine result_o
eng_valid_i  in  1  engine valid_o (stays high after completion until next start)
eng_busy_i  in  1  engine busy_o
res_valid_o  out  1  result available
res_data_o  out  32  floor(sqrt(operand))
res_operand_o  out  32  operand that produced res_data_o
res_ready_i  in  1  downstream accepts result
timeout_o  out  1  sticky: an operation was aborted by timeout
count_o  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, count_o=0, op_ready_o=1, eng_start_o=0, eng_a_o=0, res_valid_o=0, res_data_o=0, res_operand_o=0, timeout_o=0, state IDLE.
- FIFO push on op_valid_i && op_ready_o. Pointers wrap modulo DEPTH. op_ready_o=0 only when count_o==DEPTH.
- FIFO pop occurs in the ISSUE cycle. A push and a pop in the same cycle leave count unchanged. A push into an empty FIFO becomes visible to IDLE one cycle later.
- FSM:
  - IDLE: when FIFO is non-empty, load the head into eng_a_o and go to ISSUE.
  - ISSUE: eng_start_o=1 for exactly this cycle. Pop the FIFO. Clear the timer. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for eng_busy_i==1, then go to WAIT_DONE. Do not trust eng_valid_i here, because it may still be high from the previous result.
  - WAIT_DONE: on eng_valid_i==1 && eng_busy_i==0, capture eng_result_i into res_data_o and eng_a_o into res_operand_o. Set res_valid_o=1 and go to OUTPUT.
  - OUTPUT: hold res_valid_o and data until res_ready_i. On the handshake, clear res_valid_o and go to IDLE.
- eng_a_o stays stable from IDLE->ISSUE until the state leaves WAIT_DONE. It never changes while the engine is busy.
- Latency: FIFO head to eng_start_o is 2 cycles. Engine done to res_valid_o is 1 cycle.
- Back-to-back operation: with res_ready_i held at 1, OUTPUT lasts 1 cycle and the next ISSUE follows within 2 cycles.
- Timeout: a cycle counter runs in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES, set timeout_o (sticky until reset), discard the operation with no result, and go to IDLE.
- eng_start_o is never asserted outside ISSUE, and never while eng_busy_i==1.
- Reset mid-operation: all state is cleared immediately. Any in-flight result is lost. The engine is expected to share the same reset.

Optional Feature:
Macro SQRT_SEQ_CHECK_EN.
- Defined: adds output check_err_o (1 bit, sticky, reset 0). At capture, compute r=eng_result_i. Set check_err_o if r*r > a or (r+1)*(r+1) <= a, using 64-bit arithmetic. The result is still forwarded.
- Not defined: the port and the check logic are absent, and all other behaviour is identical.

Test Plan:
- Single op: push 64, engine model returns 8 -> one start pulse, res_valid_o with res_data_o=8, res_operand_o=64; timeout_o=0.
- Stale valid: first op 25->5, then push 9 while eng_valid_i is still high -> no capture before busy rises, second result 3 (not 5).
- FIFO full: res_ready_i=0, push 0,1,4,9,16,25 -> op_ready_o drops after 4 buffered plus 1 in flight; results 0,1,2,3,4,5 emerge in order once res_ready_i=1.
- Backpressure: hold res_ready_i=0 for 10 cycles -> res_valid_o stays 1, res_data_o is stable, and no new start is issued.
- Timeout: engine model never raises busy -> timeout_o=1 after 64 cycles, no result, the next operand 16 still yields 4.
- With SQRT_SEQ_CHECK_EN, engine returns 7 for 64 -> check_err_o=1. With the correct value 8 -> check_err_o stays 0.
